addr_conv_pipe: RTL and testbench

ADDR_CONV_PIPE -- requirements
Module: addr_conv_pipe

---
 rtl/addr_conv_pipe.sv | 179 +++++++++++++++++
 tb/tb_addr_conv_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_conv_pipe.sv
// rtl/addr_conv_pipe.sv - convolution tap address generator with bilinear neighbour mask
// Expands one centre command into K*K sample addresses through a two-stage pipeline.
module addr_conv_pipe #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int IDX_W     = 6,
  parameter int MAX_X     = 32,
  parameter int MAX_Y     = 32,
  parameter int K         = 3,
  parameter int DIL       = 1,
  parameter int BORDER    = 0,
  localparam int TAP_W    = $clog2(K*K)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [IDX_W-1:0]     cmd_cx,
  input  logic [IDX_W-1:0]     cmd_cy,
  input  logic                 off_valid,
  output logic                 off_ready,
  input  logic [DATA_W-1:0]    off_x,
  input  logic [DATA_W-1:0]    off_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W:0]       out_x0,
  output logic [IDX_W:0]       out_y0,
  output logic [FRAC_BITS-1:0] out_frac_x,
  output logic [FRAC_BITS-1:0] out_frac_y,
  output logic [3:0]           out_mask,
  output logic [TAP_W-1:0]     out_tap,
  output logic                 out_last,
  output logic                 busy
);

  localparam int QW   = DATA_W + 2;
  localparam int HALF = K / 2;
  localparam int NTAP = K * K;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [IDX_W-1:0]      cx_r, cy_r;
  logic [TAP_W-1:0]      tap, col, row;
  logic                  s1_valid, s1_last;
  logic signed [QW-1:0]  s1_qx, s1_qy;
  logic [TAP_W-1:0]      s1_tap;
  logic                  adv2, s1_en, cmd_fire, off_fire, tap_last;
  logic signed [QW-1:0]  px, py, qx, qy, ix, iy;
  logic signed [IDX_W:0] x0_c, y0_c;
  logic [3:0]            mask_c;

  assign adv2      = !out_valid || out_ready;
  assign s1_en     = !s1_valid || adv2;
  assign cmd_ready = (state == IDLE);
  assign off_ready = (state == RUN) && s1_en;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign off_fire  = off_valid && off_ready;
  assign tap_last  = (tap == TAP_W'(NTAP - 1));
  assign busy      = (state != IDLE) || s1_valid || out_valid;

  function automatic logic signed [IDX_W:0] clip(input logic signed [QW-1:0] v,
                                                 input int lo, input int hi);
    if (v < QW'(lo))      return (IDX_W+1)'(lo);
    else if (v > QW'(hi)) return (IDX_W+1)'(hi);
    else                  return v[IDX_W:0];
  endfunction

  function automatic logic in_rng(input logic signed [QW-1:0] v, input int hi);
    return (v >= QW'(0)) && (v <= QW'(hi));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_fire) state_n = RUN;
      RUN:     if (off_fire && tap_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // col/row track tap mod K and tap div K so no divider is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      cx_r <= '0;
      cy_r <= '0;
      tap  <= '0;
      col  <= '0;
      row  <= '0;
    end else if (cmd_fire) begin
      cx_r <= cmd_cx;
      cy_r <= cmd_cy;
      tap  <= '0;
      col  <= '0;
      row  <= '0;
    end else if (off_fire) begin
      tap <= tap + 1'b1;
      if (col == TAP_W'(K - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    px = QW'($signed({1'b0, cx_r})) + QW'((int'(col) - HALF) * DIL);
    py = QW'($signed({1'b0, cy_r})) + QW'((int'(row) - HALF) * DIL);
    qx = (px <<< FRAC_BITS) + QW'($signed(off_x));
    qy = (py <<< FRAC_BITS) + QW'($signed(off_y));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_qx    <= '0;
      s1_qy    <= '0;
      s1_tap   <= '0;
      s1_last  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= off_fire;
      if (off_fire) begin
        s1_qx   <= qx;
        s1_qy   <= qy;
        s1_tap  <= tap;
        s1_last <= tap_last;
      end
    end
  end

  // mask bits judge the unclipped neighbours; only the reported corner is clipped
  always_comb begin
    ix = s1_qx >>> FRAC_BITS;
    iy = s1_qy >>> FRAC_BITS;
    if (BORDER == 0) begin
      x0_c   = clip(ix, 0, MAX_X - 2);
      y0_c   = clip(iy, 0, MAX_Y - 2);
      mask_c = 4'hF;
    end else begin
      x0_c   = clip(ix, -1, MAX_X - 1);
      y0_c   = clip(iy, -1, MAX_Y - 1);
      mask_c = {in_rng(ix + QW'(1), MAX_X - 1) && in_rng(iy + QW'(1), MAX_Y - 1),
                in_rng(ix, MAX_X - 1)          && in_rng(iy + QW'(1), MAX_Y - 1),
                in_rng(ix + QW'(1), MAX_X - 1) && in_rng(iy, MAX_Y - 1),
                in_rng(ix, MAX_X - 1)          && in_rng(iy, MAX_Y - 1)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_x0     <= '0;
      out_y0     <= '0;
      out_frac_x <= '0;
      out_frac_y <= '0;
      out_mask   <= '0;
      out_tap    <= '0;
      out_last   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_x0     <= x0_c;
        out_y0     <= y0_c;
        out_frac_x <= s1_qx[FRAC_BITS-1:0];
        out_frac_y <= s1_qy[FRAC_BITS-1:0];
        out_mask   <= mask_c;
        out_tap    <= s1_tap;
        out_last   <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_addr_conv_pipe.sv
// tb/tb_addr_conv_pipe.sv - self-checking bench for addr_conv_pipe
// Clamp and zero-pad instances share stimulus; a scoreboard checks both against an integer model.
module tb_addr_conv_pipe;

  localparam int IDX_W = 6;
  localparam int DATA_W = 16;
  localparam int FB = 8;
  localparam int TAP_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cmd_valid, off_valid, out_ready;
  logic [IDX_W-1:0] cmd_cx, cmd_cy;
  logic [DATA_W-1:0] off_x, off_y;

  logic a_cmd_ready, a_off_ready, a_out_valid, a_out_last, a_busy;
  logic [IDX_W:0] a_x0, a_y0;
  logic [FB-1:0] a_fx, a_fy;
  logic [3:0] a_mask;
  logic [TAP_W-1:0] a_tap;
  logic b_cmd_ready, b_off_ready, b_out_valid, b_out_last, b_busy;
  logic [IDX_W:0] b_x0, b_y0;
  logic [FB-1:0] b_fx, b_fy;
  logic [3:0] b_mask;
  logic [TAP_W-1:0] b_tap;

  addr_conv_pipe #(.BORDER(0)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .off_valid(off_valid), .off_ready(a_off_ready),
    .off_x(off_x), .off_y(off_y), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_x0(a_x0), .out_y0(a_y0), .out_frac_x(a_fx), .out_frac_y(a_fy),
    .out_mask(a_mask), .out_tap(a_tap), .out_last(a_out_last), .busy(a_busy));

  addr_conv_pipe #(.BORDER(1)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .off_valid(off_valid), .off_ready(b_off_ready),
    .off_x(off_x), .off_y(off_y), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_x0(b_x0), .out_y0(b_y0), .out_frac_x(b_fx), .out_frac_y(b_fy),
    .out_mask(b_mask), .out_tap(b_tap), .out_last(b_out_last), .busy(b_busy));

  typedef struct { int x0; int y0; int fx; int fy; int mask; int tap; int last; } res_t;
  typedef struct { int cx; int cy; int tap; logic [15:0] ox; logic [15:0] oy; } stim_t;
  typedef struct { int cx; int cy; int tap; logic [15:0] ox; logic [15:0] oy; int border;
                   int x0; int y0; int fx; int fy; int mask; } vec_t;

  int tests = 0, fails = 0;
  stim_t sbq[$];
  int m_cx = 0, m_cy = 0, m_tap = 0, cyc = 0, n_out = 0;
  int first_hs = -1, first_ov = -1;
  bit prev_hold = 0, chk_stall = 0;
  res_t held_a, held_b;
  res_t cap_a[9], cap_b[9];

  function automatic int clipi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int inb(int x, int y);
    return (x >= 0 && x < 32 && y >= 0 && y < 32) ? 1 : 0;
  endfunction

  function automatic res_t model(stim_t s, int border);
    res_t r;
    int px, py, qx, qy, ix, iy;
    px = s.cx + (s.tap % 3) - 1;
    py = s.cy + (s.tap / 3) - 1;
    qx = px * 256 + int'($signed(s.ox));
    qy = py * 256 + int'($signed(s.oy));
    r.fx = ((qx % 256) + 256) % 256;
    r.fy = ((qy % 256) + 256) % 256;
    ix = (qx - r.fx) / 256;
    iy = (qy - r.fy) / 256;
    if (border == 0) begin
      r.x0 = clipi(ix, 0, 30);
      r.y0 = clipi(iy, 0, 30);
      r.mask = 15;
    end else begin
      r.x0 = clipi(ix, -1, 31);
      r.y0 = clipi(iy, -1, 31);
      r.mask = inb(ix, iy) + 2 * inb(ix + 1, iy) + 4 * inb(ix, iy + 1) + 8 * inb(ix + 1, iy + 1);
    end
    r.tap = s.tap;
    r.last = (s.tap == 8) ? 1 : 0;
    return r;
  endfunction

  function automatic res_t get_a();
    res_t r;
    r.x0 = int'($signed(a_x0)); r.y0 = int'($signed(a_y0));
    r.fx = int'(a_fx); r.fy = int'(a_fy); r.mask = int'(a_mask);
    r.tap = int'(a_tap); r.last = int'(a_out_last);
    return r;
  endfunction

  function automatic res_t get_b();
    res_t r;
    r.x0 = int'($signed(b_x0)); r.y0 = int'($signed(b_y0));
    r.fx = int'(b_fx); r.fy = int'(b_fy); r.mask = int'(b_mask);
    r.tap = int'(b_tap); r.last = int'(b_out_last);
    return r;
  endfunction

  function automatic bit res_eq(res_t g, res_t e);
    return g.x0 == e.x0 && g.y0 == e.y0 && g.fx == e.fx && g.fy == e.fy &&
           g.mask == e.mask && g.tap == e.tap && g.last == e.last;
  endfunction

  task automatic check_int(string name, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_res(string name, res_t g, res_t e);
    tests++;
    if (!res_eq(g, e)) begin
      fails++;
      $display("FAIL %s: got x0=%0d y0=%0d fx=%0d fy=%0d mask=%0d tap=%0d last=%0d expected x0=%0d y0=%0d fx=%0d fy=%0d mask=%0d tap=%0d last=%0d",
               name, g.x0, g.y0, g.fx, g.fy, g.mask, g.tap, g.last,
               e.x0, e.y0, e.fx, e.fy, e.mask, e.tap, e.last);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick(output bit ch, output bit oh);
    stim_t s;
    ch = 0;
    oh = 0;
    #1;
    if (rst) begin
      sbq.delete();
      prev_hold = 0;
      m_tap = 0;
    end else begin
      if (prev_hold) begin
        check_int("hold_valid", int'(a_out_valid && b_out_valid), 1);
        check_res("hold_a", get_a(), held_a);
        check_res("hold_b", get_b(), held_b);
      end
      if (chk_stall) begin
        check_int("stall_off_ready", int'(a_off_ready), 0);
        check_int("stall_out_valid", int'(a_out_valid), 1);
      end
      if (cmd_valid && a_cmd_ready) begin
        ch = 1;
        m_cx = int'(cmd_cx);
        m_cy = int'(cmd_cy);
        m_tap = 0;
      end
      if (off_valid && a_off_ready) begin
        oh = 1;
        sbq.push_back('{m_cx, m_cy, m_tap, off_x, off_y});
        if (first_hs < 0) first_hs = cyc;
        m_tap = (m_tap == 8) ? 0 : m_tap + 1;
      end
      if (a_out_valid && first_ov < 0) first_ov = cyc;
      if (a_out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check_int("unexpected_output", 1, 0);
        end else begin
          s = sbq.pop_front();
          check_int("valid_b", int'(b_out_valid), 1);
          check_res("scb_clamp", get_a(), model(s, 0));
          check_res("scb_zeropad", get_b(), model(s, 1));
          cap_a[s.tap] = get_a();
          cap_b[s.tap] = get_b();
          n_out++;
        end
      end
      prev_hold = a_out_valid && !out_ready;
      held_a = get_a();
      held_b = get_b();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_cmd(input int cx, input int cy, input logic [15:0] ox[9],
                         input logic [15:0] oy[9], input bit rnd, input int stall_at);
    int sent = 0, guard = 0, stalls = 0, start = n_out;
    bit cdone = 0, ch, oh;
    while ((!cdone || sent < 9 || sbq.size() != 0) && guard < 400) begin
      cmd_valid = !cdone;
      cmd_cx = IDX_W'(cx);
      cmd_cy = IDX_W'(cy);
      off_valid = cdone && sent < 9 && (!rnd || $urandom_range(0, 3) != 0);
      off_x = ox[(sent < 9) ? sent : 8];
      off_y = oy[(sent < 9) ? sent : 8];
      out_ready = !rnd || $urandom_range(0, 3) != 0;
      chk_stall = 0;
      if (sent == stall_at && stalls < 3) begin
        out_ready = 0;
        stalls++;
        chk_stall = (stalls == 3);
      end
      tick(ch, oh);
      if (ch) cdone = 1;
      if (oh) sent++;
      guard++;
    end
    cmd_valid = 0;
    off_valid = 0;
    out_ready = 1;
    chk_stall = 0;
    if (guard >= 400) check_int("cmd_timeout", guard, 0);
    check_int("result_count", n_out - start, 9);
  endtask

  initial begin
    vec_t vt[11];
    logic [15:0] ox[9], oy[9];
    res_t e, r;
    bit ch, oh;
    int guard;

    vt[0]  = '{5, 5, 0, 16'h0000, 16'h0000, 0, 4, 4, 0, 0, 15};
    vt[1]  = '{5, 5, 8, 16'h0000, 16'h0000, 0, 6, 6, 0, 0, 15};
    vt[2]  = '{5, 5, 4, 16'h0180, 16'hFF80, 0, 6, 4, 128, 128, 15};
    vt[3]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, -1, -1, 0, 0, 8};
    vt[4]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 15};
    vt[5]  = '{31, 31, 8, 16'h0000, 16'h0000, 1, 31, 31, 0, 0, 0};
    vt[6]  = '{31, 31, 8, 16'h0000, 16'h0000, 0, 30, 30, 0, 0, 15};
    vt[7]  = '{5, 5, 4, 16'h0180, 16'hFF80, 1, 6, 4, 128, 128, 15};
    vt[8]  = '{31, 0, 2, 16'h0000, 16'h0000, 1, 31, -1, 0, 0, 0};
    vt[9]  = '{31, 15, 4, 16'h0000, 16'h0000, 1, 31, 15, 0, 0, 5};
    vt[10] = '{5, 5, 4, 16'hF000, 16'h0000, 0, 0, 5, 0, 0, 15};

    rst = 1; cmd_valid = 0; off_valid = 0; out_ready = 1;
    cmd_cx = '0; cmd_cy = '0; off_x = '0; off_y = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check_int("rst_out_valid", int'(a_out_valid || b_out_valid), 0);
    check_int("rst_busy", int'(a_busy || b_busy), 0);
    check_int("rst_cmd_ready", int'(a_cmd_ready && b_cmd_ready), 1);
    check_int("rst_off_ready", int'(a_off_ready), 0);
    check_int("rst_out_data", int'({a_x0, a_y0, a_fx, a_fy, a_mask, a_tap, a_out_last} != '0), 0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      for (int t = 0; t < 9; t++) begin ox[t] = 16'h0; oy[t] = 16'h0; end
      ox[vt[i].tap] = vt[i].ox;
      oy[vt[i].tap] = vt[i].oy;
      first_hs = -1;
      first_ov = -1;
      run_cmd(vt[i].cx, vt[i].cy, ox, oy, 0, -1);
      r = (vt[i].border != 0) ? cap_b[vt[i].tap] : cap_a[vt[i].tap];
      e = '{vt[i].x0, vt[i].y0, vt[i].fx, vt[i].fy, vt[i].mask, vt[i].tap,
            (vt[i].tap == 8) ? 1 : 0};
      check_res($sformatf("vec%0d", i), r, e);
      if (i == 0) begin
        check_int("latency", first_ov - first_hs, 2);
        for (int t = 0; t < 9; t++) begin
          e = '{4 + t % 3, 4 + t / 3, 0, 0, 15, t, (t == 8) ? 1 : 0};
          check_res($sformatf("centre5_tap%0d", t), cap_a[t], e);
        end
      end
    end

    for (int t = 0; t < 9; t++) begin ox[t] = 16'($urandom); oy[t] = 16'($urandom); end
    run_cmd(7, 9, ox, oy, 0, 4);

    cmd_valid = 1; cmd_cx = 6'd10; cmd_cy = 6'd12;
    tick(ch, oh);
    check_int("midrst_cmd_accept", int'(ch), 1);
    cmd_valid = 0;
    guard = 0;
    while (m_tap != 4 && guard < 50) begin
      off_valid = 1; off_x = 16'($urandom); off_y = 16'($urandom); out_ready = 1;
      tick(ch, oh);
      guard++;
    end
    check_int("midrst_reach_tap4", m_tap, 4);
    rst = 1;
    tick(ch, oh);
    rst = 0;
    off_valid = 0;
    #1;
    check_int("midrst_out_valid", int'(a_out_valid || b_out_valid), 0);
    check_int("midrst_busy", int'(a_busy || b_busy), 0);
    check_int("midrst_cmd_ready", int'(a_cmd_ready), 1);
    @(negedge clk);
    for (int t = 0; t < 9; t++) begin ox[t] = 16'h0; oy[t] = 16'h0; end
    run_cmd(3, 3, ox, oy, 0, -1);
    e = '{2, 2, 0, 0, 15, 0, 0};
    check_res("midrst_restart_tap0", cap_a[0], e);

    for (int n = 0; n < 25; n++) begin
      for (int t = 0; t < 9; t++) begin ox[t] = 16'($urandom); oy[t] = 16'($urandom); end
      run_cmd(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), ox, oy, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
